// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM burst scheduler.
// Holds the scheduler state enum, header sync byte and channel count.
package sdram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] HDR_SYNC = 8'hA5;
    localparam int         NUM_CH   = 4;

endpackage

// File: rtl/sdram_burst_sched_if.sv
// Bus bundle between the scheduler, the four channel read FIFOs,
// the SSD-side write FIFO and the upstream readiness controller.
// master: scheduler side (drives strobes, write data, status).
// slave : environment side (drives ack and channel read data).
interface sdram_burst_sched_if #(
    parameter int DATA_W = 16
);
    logic              ack;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic [DATA_W-1:0] rd_data_3;
    logic [DATA_W-1:0] rd_data_4;
    logic              rd_req_1;
    logic              rd_req_2;
    logic              rd_req_3;
    logic              rd_req_4;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_cnt;

    modport master (
        input  ack,
        input  rd_data_1, rd_data_2, rd_data_3, rd_data_4,
        output rd_req_1, rd_req_2, rd_req_3, rd_req_4,
        output wr_req, wr_data,
        output busy, frame_done, frame_cnt
    );

    modport slave (
        output ack,
        output rd_data_1, rd_data_2, rd_data_3, rd_data_4,
        input  rd_req_1, rd_req_2, rd_req_3, rd_req_4,
        input  wr_req, wr_data,
        input  busy, frame_done, frame_cnt
    );

endinterface

// File: rtl/sdram_burst_sched_rd_data_mux.sv
// Write pipeline stage 2: registered 4:1 channel data mux with header insert.
// Ports: clk, nRST, in_valid/in_ch (+in_hdr when SDRAM_BURST_HDR_EN),
// rd_data_1..4 (FIFO q), wr_req/wr_data (write FIFO strobe and data).
module rd_data_mux
    import sdram_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              in_valid,
`ifdef SDRAM_BURST_HDR_EN
    input  logic              in_hdr,
`endif
    input  logic [1:0]        in_ch,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    input  logic [DATA_W-1:0] rd_data_3,
    input  logic [DATA_W-1:0] rd_data_4,
    output logic              wr_req,
    output logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] sel_data;

`ifdef SDRAM_BURST_HDR_EN
    localparam int PAD_W = DATA_W - 10;
    logic [DATA_W-1:0] hdr_word;
    assign hdr_word = {HDR_SYNC, {PAD_W{1'b0}}, in_ch};
`endif

    always_comb begin
        sel_data = rd_data_1;
        unique case (in_ch)
            2'd0: sel_data = rd_data_1;
            2'd1: sel_data = rd_data_2;
            2'd2: sel_data = rd_data_3;
            2'd3: sel_data = rd_data_4;
        endcase
`ifdef SDRAM_BURST_HDR_EN
        if (in_hdr) begin
            sel_data = hdr_word;
        end
`endif
    end

    // wr_data holds its last value between writes; only wr_req qualifies it.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_req  <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_req <= in_valid;
            if (in_valid) begin
                wr_data <= sel_data;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_sched.sv
// Frame scheduler: on ack, moves one BURST_LEN burst from each channel FIFO
// (1..4) into the write FIFO through a fixed 2-cycle write pipeline.
// Ports: clk, nRST (async active-low), bus (sdram_burst_sched_if.master).
// Build option: SDRAM_BURST_HDR_EN adds a header word before each burst.
module sdram_burst_sched
    import sdram_ctrl_pkg::*;
#(
    parameter int BURST_LEN = 64,
    parameter int DATA_W    = 16
) (
    input  logic                clk,
    input  logic                nRST,
    sdram_burst_sched_if.master bus
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

`ifdef SDRAM_BURST_HDR_EN
    localparam state_t BURST_ENTRY = HDR;
`else
    localparam state_t BURST_ENTRY = RD;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ch;
    logic [1:0]       ch_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             drain_cnt;
    logic             drain_nxt;
    logic             rd_sel_valid;
    logic [15:0]      frame_cnt;
    logic             frame_done;

    // Stage 1 of the write pipeline.
    logic             s1_valid;
    logic [1:0]       s1_ch;

`ifdef SDRAM_BURST_HDR_EN
    logic             hdr_sel;
    logic             s1_hdr;
`endif

    logic              wr_req;
    logic [DATA_W-1:0] wr_data;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ch        <= 2'd0;
            cnt       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            cnt       <= cnt_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ch_nxt       = ch;
        cnt_nxt      = cnt;
        drain_nxt    = drain_cnt;
        rd_sel_valid = 1'b0;
`ifdef SDRAM_BURST_HDR_EN
        hdr_sel      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                ch_nxt    = 2'd0;
                cnt_nxt   = '0;
                drain_nxt = 1'b0;
                if (bus.ack) begin
                    state_nxt = BURST_ENTRY;
                end
            end
            HDR: begin
`ifdef SDRAM_BURST_HDR_EN
                hdr_sel   = 1'b1;
                state_nxt = RD;
`else
                state_nxt = IDLE;
`endif
            end
            RD: begin
                rd_sel_valid = 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (ch == 2'd3) begin
                        state_nxt = DRAIN;
                        drain_nxt = 1'b0;
                    end else begin
                        ch_nxt    = ch + 2'd1;
                        state_nxt = BURST_ENTRY;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: begin
                drain_nxt = 1'b1;
                if (drain_cnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s1_valid <= 1'b0;
            s1_ch    <= 2'd0;
`ifdef SDRAM_BURST_HDR_EN
            s1_hdr   <= 1'b0;
`endif
        end else begin
            s1_ch    <= ch;
`ifdef SDRAM_BURST_HDR_EN
            s1_valid <= rd_sel_valid | hdr_sel;
            s1_hdr   <= hdr_sel;
`else
            s1_valid <= rd_sel_valid;
`endif
        end
    end

    rd_data_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .clk       (clk),
        .nRST      (nRST),
        .in_valid  (s1_valid),
`ifdef SDRAM_BURST_HDR_EN
        .in_hdr    (s1_hdr),
`endif
        .in_ch     (s1_ch),
        .rd_data_1 (bus.rd_data_1),
        .rd_data_2 (bus.rd_data_2),
        .rd_data_3 (bus.rd_data_3),
        .rd_data_4 (bus.rd_data_4),
        .wr_req    (wr_req),
        .wr_data   (wr_data)
    );

    // The final write of a frame lands in the second DRAIN cycle.
    assign frame_done = (state == DRAIN) && drain_cnt;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            frame_cnt <= 16'd0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Strobes decode straight from registered state so reset clears them at once.
    assign bus.rd_req_1   = rd_sel_valid && (ch == 2'd0);
    assign bus.rd_req_2   = rd_sel_valid && (ch == 2'd1);
    assign bus.rd_req_3   = rd_sel_valid && (ch == 2'd2);
    assign bus.rd_req_4   = rd_sel_valid && (ch == 2'd3);
    assign bus.wr_req     = wr_req;
    assign bus.wr_data    = wr_data;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = frame_done;
    assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Randomized self-checking bench for sdram_burst_sched (BURST_LEN=4).
// FIFO model feeds random words; a scoreboard checks order, latency, framing.
module tb_sdram_burst_sched;

    localparam int BL = 4;
    localparam int DW = 16;
`ifdef SDRAM_BURST_HDR_EN
    localparam int HDRS = 1;
`else
    localparam int HDRS = 0;
`endif
    localparam int WPF  = 4 * (BL + HDRS);
    localparam int FLEN = 4 * BL + 1 + 3 * HDRS;
    localparam int GAP  = 2 + HDRS;
    localparam int MEMD = 1024;

    typedef struct {
        int          c;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic nRST = 1'b0;

    sdram_burst_sched_if #(.DATA_W(DW)) bus ();

    sdram_burst_sched #(
        .BURST_LEN (BL),
        .DATA_W    (DW)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [15:0] mem [4][MEMD];
    int          rp [4];
    logic [15:0] rdv [4];
    logic [3:0]  pend = 4'b0;
    ent_t        expq [$];
    int          rd_n = 0;
    int          wr_n = 0;
    int          exp_frames = 0;
    int          first_rd_cyc = 0;
    int          last_done_cyc = 0;
    bit          have_done = 1'b0;
    bit          hold_mode = 1'b0;

    logic [3:0]  rv;
    int          idx;
    int          ech;
    bit          exp_done;
    ent_t        e;

    assign bus.rd_data_1 = rdv[0];
    assign bus.rd_data_2 = rdv[1];
    assign bus.rd_data_3 = rdv[2];
    assign bus.rd_data_4 = rdv[3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] rd_vec();
        return {bus.rd_req_4, bus.rd_req_3, bus.rd_req_2, bus.rd_req_1};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Non-showahead FIFOs: q changes just after the edge that saw rd_req.
    always @(posedge clk) begin
        #1;
        if (nRST) begin
            for (int k = 0; k < 4; k++) begin
                if (pend[k]) begin
                    rdv[k] = mem[k][rp[k]];
                    rp[k]  = rp[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        rv = rd_vec();
        if (!nRST) begin
            expq.delete();
            rd_n       = 0;
            wr_n       = 0;
            exp_frames = 0;
            have_done  = 1'b0;
            pend       = 4'b0;
        end else begin
            pend = rv;
            chk("rd_onehot", 32'($countones(rv) <= 1), 32'd1);
            if (rv != 4'b0 || bus.wr_req) chk("busy_act", 32'(bus.busy), 32'd1);
            if (rv != 4'b0) begin
                idx = 0;
                for (int k = 3; k >= 0; k--) if (rv[k]) idx = k;
                ech = (rd_n / BL) % 4;
                chk("rd_ch", 32'(idx), 32'(ech));
                if (rd_n % (4 * BL) == 0) begin
                    first_rd_cyc = cyc;
                    if (hold_mode && have_done)
                        chk("frame_gap", 32'(cyc - last_done_cyc), 32'(GAP));
                end
                if (HDRS != 0 && rd_n % BL == 0)
                    expq.push_back('{cyc - 1, 16'hA500 | 16'(ech)});
                expq.push_back('{cyc, mem[idx][rp[idx]]});
                rd_n++;
            end
            exp_done = bus.wr_req && ((wr_n + 1) % WPF == 0);
            chk("frame_done", 32'(bus.frame_done), 32'(exp_done));
            if (bus.wr_req) begin
                if (expq.size() == 0) begin
                    chk("wr_spurious", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("wr_data", 32'(bus.wr_data), 32'(e.d));
                    chk("wr_lat", 32'(cyc - e.c), 32'd2);
                end
                wr_n++;
                if (wr_n % WPF == 0) begin
                    exp_frames++;
                    chk("frame_len", 32'(cyc - first_rd_cyc), 32'(FLEN));
                    last_done_cyc = cyc;
                    have_done     = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (bus.busy && k < bound) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_rd(input logic [3:0] mask, input int bound);
        int k = 0;
        while ((rd_vec() & mask) == 4'b0 && k < bound) begin
            step();
            k++;
        end
        chk("rd_timeout", 32'((rd_vec() & mask) != 4'b0), 32'd1);
    endtask

    initial begin
        int w0;
        bus.ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rp[c]  = 0;
            rdv[c] = '0;
            for (int i = 0; i < MEMD; i++) mem[c][i] = 16'($urandom);
        end

        repeat (3) step();
        chk("rst_rd", 32'(rd_vec()), 32'd0);
        chk("rst_wr", 32'(bus.wr_req), 32'd0);
        chk("rst_wdata", 32'(bus.wr_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
        nRST = 1'b1;

        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_rd", 32'(rd_vec()), 32'd0);
            chk("idle_wr", 32'(bus.wr_req), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        chk("idle_fcnt", 32'(bus.frame_cnt), 32'd0);

        w0 = wr_n;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        repeat (HDRS) step();
        chk("start_rd1", 32'(rd_vec()), 32'd1);
        wait_idle(200);
        chk("pulse_words", 32'(wr_n - w0), 32'(WPF));
        chk("pulse_fcnt", 32'(bus.frame_cnt), 32'd1);

        w0 = wr_n;
        hold_mode = 1'b1;
        bus.ack = 1'b1;
        for (int k = 0; k < 400 && exp_frames < 4; k++) step();
        bus.ack = 1'b0;
        wait_idle(200);
        hold_mode = 1'b0;
        chk("hold_words", 32'(wr_n - w0), 32'(3 * WPF));
        chk("hold_fcnt", 32'(bus.frame_cnt), 32'd4);

        w0 = wr_n;
        bus.ack = 1'b1;
        wait_rd(4'b0001, 20);
        step();
        step();
        bus.ack = 1'b0;
        wait_idle(200);
        chk("drop_words", 32'(wr_n - w0), 32'(WPF));
        chk("drop_fcnt", 32'(bus.frame_cnt), 32'd5);

        bus.ack = 1'b1;
        wait_rd(4'b0100, 100);
        step();
        nRST = 1'b0;
        #1;
        chk("mrst_rd", 32'(rd_vec()), 32'd0);
        chk("mrst_wr", 32'(bus.wr_req), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.frame_done), 32'd0);
        chk("mrst_fcnt", 32'(bus.frame_cnt), 32'd0);
        repeat (3) step();
        nRST = 1'b1;
        wait_rd(4'b1111, 20);
        chk("mrst_first", 32'(rd_vec()), 32'd1);
        bus.ack = 1'b0;
        wait_idle(200);
        chk("mrst_fcnt1", 32'(bus.frame_cnt), 32'd1);

        for (int i = 0; i < 800; i++) begin
            bus.ack = ($urandom_range(0, 3) == 0);
            step();
        end
        bus.ack = 1'b0;
        wait_idle(200);
        step();
        chk("sb_empty", 32'(expq.size()), 32'd0);
        chk("rand_fcnt", 32'(bus.frame_cnt), 32'(exp_frames));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
